// File: rtl/serial_out8_if.sv
// Byte-in / bit-out handshake bundle for serial_out8.
// The master side offers bytes and watches the serial stream; the slave side is the serializer.
interface serial_out8_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       frame_start;
    logic       busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, frame_start, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, frame_start, busy
    );
endinterface

// File: rtl/serial_out8.sv
// Parallel-to-serial byte shifter, DIV clocks per bit, back-to-back frames without gaps.
// Define SERIAL_OUT8_PARITY_EN to append an even-parity bit after the 8 data bits.
module serial_out8 #(
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    serial_out8_if.slave  bus
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

`ifdef SERIAL_OUT8_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t     state_reg;
    logic [7:0] div_cnt_reg;
    logic [3:0] bit_idx_reg;
    logic [7:0] data_reg;
    logic       ser_out_reg;
    logic       ser_valid_reg;
    logic       frame_start_reg;
    logic       busy_reg;

    logic       bit_done;
    logic       final_bit;
    logic       in_ready;
    logic       accept;
    logic [2:0] next_idx;

    function automatic logic pick(input logic [7:0] d, input logic [2:0] idx);
        return MSB_FIRST ? d[3'd7 - idx] : d[idx];
    endfunction

    assign bit_done = (div_cnt_reg == DIV_LAST);
`ifdef SERIAL_OUT8_PARITY_EN
    assign final_bit = (state_reg == PARITY);
`else
    assign final_bit = (state_reg == SHIFT) && (bit_idx_reg == 4'd7);
`endif
    // Gated by rst so the handshake reads 0 for the whole reset window, not just after an edge.
    assign in_ready = !rst && ((state_reg == IDLE) || (final_bit && bit_done));
    assign accept   = bus.in_valid && in_ready;
    assign next_idx = bit_idx_reg[2:0] + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            div_cnt_reg     <= 8'd0;
            bit_idx_reg     <= 4'd0;
            data_reg        <= 8'd0;
            ser_out_reg     <= 1'b0;
            ser_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (accept) begin
                // New frame: first bit goes straight into the output register.
                state_reg       <= SHIFT;
                data_reg        <= bus.in_data;
                div_cnt_reg     <= 8'd0;
                bit_idx_reg     <= 4'd0;
                ser_out_reg     <= pick(bus.in_data, 3'd0);
                ser_valid_reg   <= 1'b1;
                frame_start_reg <= 1'b1;
                busy_reg        <= 1'b1;
            end else begin
                case (state_reg)
                    SHIFT: begin
                        if (bit_done) begin
                            div_cnt_reg <= 8'd0;
                            if (bit_idx_reg == 4'd7) begin
`ifdef SERIAL_OUT8_PARITY_EN
                                state_reg   <= PARITY;
                                bit_idx_reg <= 4'd8;
                                ser_out_reg <= ^data_reg;
`else
                                state_reg     <= IDLE;
                                bit_idx_reg   <= 4'd0;
                                ser_out_reg   <= 1'b0;
                                ser_valid_reg <= 1'b0;
                                busy_reg      <= 1'b0;
`endif
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 4'd1;
                                ser_out_reg <= pick(data_reg, next_idx);
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 8'd1;
                        end
                    end
`ifdef SERIAL_OUT8_PARITY_EN
                    PARITY: begin
                        if (bit_done) begin
                            state_reg     <= IDLE;
                            div_cnt_reg   <= 8'd0;
                            bit_idx_reg   <= 4'd0;
                            ser_out_reg   <= 1'b0;
                            ser_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                        end else begin
                            div_cnt_reg <= div_cnt_reg + 8'd1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.ser_out     = ser_out_reg;
    assign bus.ser_valid   = ser_valid_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.busy        = busy_reg;

endmodule
